// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle.
//   H   : row sense lines, active-low (driven by the keypad)
//   V   : column drive lines, active-low, one-hot low (driven by the scanner)
//   ack : one-cycle strobe for a new debounced key press
//   cmd : code (row*4 + col) of the last reported press
// Modports: slave = scanner side, master = keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] H;
    logic [3:0] V;
    logic       ack;
    logic [3:0] cmd;

    modport master (output H, input V, input ack, input cmd);
    modport slave  (input H, output V, output ack, output cmd);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-level debounce.
// Each column is driven low for SCAN_DIV cycles; rows are sampled on the last
// cycle of each column slot. Four slots form one frame; at frame end the
// sixteen samples are classified (none / single / multi) and a four-state
// debounce FSM reports a new press with a one-cycle ack and the key code.
// Ports:
//   Clock : system clock, rising edge
//   Reset : asynchronous, active-high
//   kp    : keypad_scan_if.slave (H in, V/ack/cmd out)
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    keypad_scan_if.slave kp
);
    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB       = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    logic [15:0] div;
    logic [1:0]  col;
    logic [15:0] acc;
    logic [15:0] acc_merged;
    logic        frame_end;

    logic [4:0]  key_cnt;
    logic [3:0]  key_code;
    logic        is_none;
    logic        is_single;

    state_t      state, state_n;
    logic [3:0]  cand, cand_n;
    logic [3:0]  count, count_n;
    logic [3:0]  count_inc;
    logic        report;
    logic        ack_q;
    logic [3:0]  cmd_q;

    assign frame_end = (div == DIV_LAST) && (col == 2'd3);

    // Accumulator with the current column's rows folded in, so the frame-end
    // classification sees column 3 without waiting another cycle.
    always_comb begin
        acc_merged = acc;
        for (int unsigned r = 0; r < 4; r++) begin
            acc_merged[{r[1:0], col}] = ~kp.H[r[1:0]];
        end
    end

    // Scan timing and frame accumulation run regardless of FSM state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div <= '0;
            col <= '0;
            acc <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            col <= col + 2'd1;
            acc <= (col == 2'd3) ? '0 : acc_merged;
        end else begin
            div <= div + 16'd1;
        end
    end

    always_comb begin
        key_cnt  = '0;
        key_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (acc_merged[i[3:0]]) begin
                key_cnt  = key_cnt + 5'd1;
                key_code = i[3:0];
            end
        end
        is_none   = (key_cnt == 5'd0);
        is_single = (key_cnt == 5'd1);
    end

    assign count_inc = count + 4'd1;

    // State register; ack/cmd are registered so they appear the cycle after
    // the frame-end sample.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cand  <= '0;
            count <= '0;
            ack_q <= 1'b0;
            cmd_q <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            count <= count_n;
            ack_q <= report;
            if (report) begin
                cmd_q <= cand_n;
            end
        end
    end

    // Next-state logic, evaluated only at frame end.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        count_n = count;
        report  = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_n = key_code;
                        if (DB == 4'd1) begin
                            state_n = HELD;
                            report  = 1'b1;
                        end else begin
                            state_n = PRESS;
                            count_n = 4'd1;
                        end
                    end
                end
                PRESS: begin
                    if (is_single && key_code == cand) begin
                        count_n = count_inc;
                        if (count_inc == DB) begin
                            state_n = HELD;
                            report  = 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                        count_n = '0;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        // With a single-frame debounce the release completes at once.
                        if (DB == 4'd1) begin
                            state_n = IDLE;
                            count_n = '0;
                        end else begin
                            state_n = RELEASE;
                            count_n = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        count_n = count_inc;
                        if (count_inc == DB) begin
                            state_n = IDLE;
                            count_n = '0;
                        end
                    end else begin
                        state_n = HELD;
                        count_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    // Output logic.
    always_comb begin
        kp.V   = ~(4'b0001 << col);
        kp.ack = ack_q;
        kp.cmd = cmd_q;
    end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column stays driven; legal range 2..65535.
REQ-002 Parameter DEBOUNCE, default 4: consecutive identical full-scan frames required to accept a press or a release; legal range 1..15.
REQ-003 Port Clock  input  1  system clock; all state updates on the rising edge.
REQ-004 Port Reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 Port H  input  4  keypad row sense lines, active-low (pulled up externally); bit r is row r.
REQ-006 Port V  output  4  keypad column drive lines, active-low, exactly one low at any time.
REQ-007 Port ack  output  1  one-cycle strobe: a new debounced key press is reported.
REQ-008 Port cmd  output  4  key code of the last reported press, code = row*4 + col.

Function
REQ-009 Column index c cycles 0,1,2,3,0,...; V SHALL equal ~(4'b0001 << c).
REQ-010 A divider SHALL hold each column for exactly SCAN_DIV cycles; c advances on the cycle after the divider reaches SCAN_DIV-1.
REQ-011 H SHALL be sampled only on the last cycle of each column slot (divider = SCAN_DIV-1), giving settle time after V changes.
REQ-012 One frame = 4 slots = 4*SCAN_DIV cycles; frame end is the sample of column 3.
REQ-013 Per frame the block SHALL classify the 16 samples: NONE (no key low), SINGLE(code) (exactly one key low), MULTI (two or more low).
REQ-014 FSM states: IDLE, PRESS, HELD, RELEASE; evaluated only at frame end.
REQ-015 IDLE: SINGLE(k) -> PRESS with candidate = k, count = 1; NONE or MULTI -> stay.
REQ-016 PRESS: SINGLE(candidate) -> count+1; NONE -> IDLE; MULTI or SINGLE(other) -> IDLE.
REQ-017 PRESS: when count reaches DEBOUNCE -> HELD, and ack pulses with cmd = candidate.
REQ-018 With DEBOUNCE = 1, SINGLE(k) in IDLE SHALL go directly to HELD with ack.
REQ-019 HELD: NONE -> RELEASE with count = 1; SINGLE or MULTI (any key) -> stay; no further ack.
REQ-020 RELEASE: NONE -> count+1, reaching DEBOUNCE -> IDLE; SINGLE or MULTI -> HELD.
REQ-021 A second key pressed while one is held SHALL NOT be reported until all keys release for DEBOUNCE frames.
REQ-022 ack SHALL assert on the cycle after the frame-end sample that completes debounce, for exactly one cycle.
REQ-023 cmd SHALL update in the same cycle ack asserts and hold its value until the next ack.
REQ-024 Press latency from a stable press to ack: DEBOUNCE frames after the first frame containing it, plus one cycle; no auto-repeat.
REQ-025 Divider, column index and frame accumulator SHALL run continuously, independent of FSM state.

Reset
REQ-026 While Reset is high: V = 4'b1110, ack = 0, cmd = 0, divider = 0, c = 0, accumulator cleared, count = 0, state = IDLE.
REQ-027 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame and count; the first scan after release starts at column 0 with a fresh frame.
REQ-028 A key held through reset release SHALL be reported once after DEBOUNCE full frames, as a new press.

Verification (SCAN_DIV = 4, DEBOUNCE = 3; frame = 16 cycles)
REQ-029 Reset, no key -> V rotates 1110,1101,1011,0111, 4 cycles each; ack never asserts.
REQ-030 Row 2 pulled low whenever V[1]=0 (key 9), held 5 frames -> single ack, one cycle after the 3rd frame end, cmd = 4'd9.
REQ-031 Key 9 present for 2 frames then released -> no ack; cmd stays 0.
REQ-032 Key 5 held, release 1 frame, press again -> no second ack; release 3 frames then press key 5 -> second ack with cmd = 4'd5.
REQ-033 Keys 0 and 15 pressed together for 6 frames -> no ack; state returns to IDLE after frames without a key.
REQ-034 Reset pulsed during the 2nd debounce frame of key 3 held throughout -> ack with cmd = 4'd3 exactly 3 frames plus one cycle after reset release, V = 1110 during reset.
